mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller driving the data-cache request port and the input side of the MEM/WB pipeline latch. It takes the EX/MEM outputs, issues exactly one dmem read or write per memory instruction, and generates `mem_stall` for the hazard unit. It holds completed load data across MEM/WB freezes and latches the program halt. It produces every `*_i` signal of `mem_wb_if`.

## Interface
- `CNT_W`, 16: width of the stall-cycle performance counter.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `exm_valid`  in  1  EX/MEM holds a live (non-bubble) instruction.
- `exm_dREN`, `exm_dWEN`  in  1 each  load / store request from EX/MEM; never both high.
- `exm_alu_out`  in  word_t  effective address / ALU result.
- `exm_store`  in  word_t  store data.
- `exm_regWr`, `exm_halt`  in  1  control passthrough.
- `exm_mem_to_reg`  in  2  writeback source select.
- `exm_wsel`  in  regbits_t  destination register.
- `exm_pc_p4`, `exm_up_imm`, `exm_instr`  in  word_t  passthrough.
- `dhit`  in  1  cache completes the current access this cycle.
- `dmemload`  in  word_t  cache read data, valid with `dhit`.
- `dmemREN`, `dmemWEN`  out  1  cache request.
- `dmemaddr`, `dmemstore`  out  word_t  cache address / store data.
- `wb_en`  in  1  MEM/WB `en` (latch captures this cycle).
- `wb_flush`  in  1  MEM/WB `flush`.
- `mem_stall`  out  1  to hazard unit: freeze IF..EX/MEM.
- `memwb_*`  out  —  `regWr_i`, `halt_i`, `mem_to_reg_i`, `dmem_load_i`, `alu_out_i`, `pc_p4_i`, `up_imm_i`, `imem_load_i`, `wsel_i`.
- `halted`  out  1  sticky halt flag.
- `stall_cnt`  out  CNT_W  saturating count of `mem_stall` cycles.

## Operation
- Memory op: `op = exm_valid & (exm_dREN | exm_dWEN)`.
- States: IDLE, HOLD, HALTED.
- IDLE:
  - `dmemREN/WEN = exm_dREN/dWEN & exm_valid`; address is `exm_alu_out`, store data is `exm_store`.
  - `mem_stall = op & ~dhit`.
  - On `op & dhit & ~wb_en`: capture `dmemload` into `ld_hold`, go to HOLD.
  - On `op & dhit & wb_en`: remain in IDLE; the access is complete.
- HOLD:
  - Cache request deasserted; prevents a duplicate store or a repeated load miss.
  - `mem_stall = 0`.
  - `dmem_load_i = ld_hold`.
  - When `wb_en`, go to IDLE.
- `dmem_load_i` in IDLE is `dmemload` when `dhit`, else `ld_hold`.
- All other `memwb_*` pass through combinationally from `exm_*`.
  - `imem_load_i = exm_instr`.
  - `regWr_i`/`halt_i` are gated by `exm_valid`.
- Halt: when `exm_valid & exm_halt & wb_en` with no pending op, go to HALTED. From HALTED:
  - `halted = 1`.
  - Cache requests are forced low.
  - `mem_stall = 0`.
  - Only `RST` exits.
- Flush:
  - `wb_flush` is ignored for request generation while `mem_stall = 1`, because an in-flight cache transaction is never abandoned.
  - In HOLD, `wb_flush` returns to IDLE and discards `ld_hold`.
- `stall_cnt` increments each cycle `mem_stall = 1` and saturates at all-ones.

## Timing
- Reset values:
  - state IDLE; `ld_hold` 0; `halted` 0; `stall_cnt` 0.
  - `dmemREN/WEN` 0 in the reset cycle (forced).
  - `mem_stall` 0.
- Hit latency:
  - A same-cycle `dhit` means zero added cycles.
  - A miss of N cycles raises `mem_stall` for N cycles; it drops in the cycle `dhit` is high.
- A request stays stable (address, data, enables) from its first cycle until the `dhit` cycle inclusive.
- Back-to-back memory ops:
  - A new op in the cycle after completion issues immediately; there is no bubble.
  - The op is new because EX/MEM advanced.
- `dhit` with `exm_valid = 0` or in HOLD/HALTED is ignored.
- `RST` mid-access: the request drops the same edge, and the partial transaction is abandoned.

## Structure
- `cpu_types_pkg` supplies `word_t`, `regbits_t` and the `mem_to_reg` encodings.
- Add `memstate_t` (IDLE/HOLD/HALTED) to `cpu_types_pkg` for tracker visibility.
- Single module. `stall_cnt` is a natural sub-module: `sat_counter` (parameter `W`; ports `inc`, `clr`, `q`).

## Test plan
- Load hit: `exm_dREN = 1`, addr `0x100`, `dhit` same cycle with `dmemload = 0xDEADBEEF`, `wb_en = 1` → `dmem_load_i = 0xDEADBEEF`, `mem_stall` never high, `stall_cnt = 0`.
- Store miss: `exm_dWEN = 1`, addr `0x200`, data `0x12345678`, `dhit` after 3 cycles → `mem_stall` high exactly 3 cycles, request stable throughout, `stall_cnt = 3`.
- Freeze after hit: load, `dhit` with `dmemload = 0xCAFE0001`, `wb_en = 0` for 2 cycles → HOLD, `dmemREN = 0`, `dmem_load_i = 0xCAFE0001` until `wb_en`, then IDLE.
- Duplicate store guard: store hit with `wb_en = 0` for 2 cycles → `dmemWEN` high exactly 1 cycle.
- Halt: `exm_halt = 1`, `wb_en = 1`, then present a load → `halted = 1`, `dmemREN` stays 0, `mem_stall = 0`; `RST` clears all state.
- Reset mid-miss: assert `RST` during the 2nd stall cycle → next cycle `dmemREN = 0`, `mem_stall = 0`, `stall_cnt = 0`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types and memory-stage state encoding
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   // Writeback source select encodings carried on mem_to_reg
   localparam logic [1:0] MTR_ALU = 2'd0;
   localparam logic [1:0] MTR_MEM = 2'd1;
   localparam logic [1:0] MTR_PC4 = 2'd2;
   localparam logic [1:0] MTR_LUI = 2'd3;

   // Memory-stage access tracker state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } memstate_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-cache request/response port
interface mem_access_unit_if;
   import cpu_types_pkg::*;

   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  dhit;
   word_t dmemload;

   // Requester side (memory stage)
   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   // Responder side (data cache)
   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise step until all-ones and stick there
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge CLK) begin
      cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage dcache access controller feeding MEM/WB
module mem_access_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              exm_valid,
   input  logic              exm_dREN,
   input  logic              exm_dWEN,
   input  word_t             exm_alu_out,
   input  word_t             exm_store,
   input  logic              exm_regWr,
   input  logic              exm_halt,
   input  logic [1:0]        exm_mem_to_reg,
   input  regbits_t          exm_wsel,
   input  word_t             exm_pc_p4,
   input  word_t             exm_up_imm,
   input  word_t             exm_instr,
   mem_access_unit_if.master dif,
   input  logic              wb_en,
   input  logic              wb_flush,
   output logic              mem_stall,
   output logic              memwb_regWr_i,
   output logic              memwb_halt_i,
   output logic [1:0]        memwb_mem_to_reg_i,
   output word_t             memwb_dmem_load_i,
   output word_t             memwb_alu_out_i,
   output word_t             memwb_pc_p4_i,
   output word_t             memwb_up_imm_i,
   output word_t             memwb_imem_load_i,
   output regbits_t          memwb_wsel_i,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt
);

   memstate_t state_q, state_d;
   word_t     ld_hold_q, ld_hold_d;
   logic      op;

   assign op = exm_valid & (exm_dREN | exm_dWEN);

   // State and held-load registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         ld_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         ld_hold_q <= ld_hold_d;
      end
   end

   // Next state: park completed loads while MEM/WB is frozen, latch halt
   always_comb begin
      state_d   = state_q;
      ld_hold_d = ld_hold_q;
      unique case (state_q)
         IDLE: begin
            if (op && dif.dhit && !wb_en) begin
               state_d   = HOLD;
               ld_hold_d = dif.dmemload;
            end else if (exm_valid && exm_halt && wb_en && !op) begin
               state_d = HALTED;
            end
         end
         HOLD: begin
            if (wb_flush) begin
               state_d   = IDLE;
               ld_hold_d = '0;
            end else if (wb_en) begin
               state_d = IDLE;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: cache request only from IDLE; reset forces the request off
   always_comb begin
      dif.dmemREN       = 1'b0;
      dif.dmemWEN       = 1'b0;
      mem_stall         = 1'b0;
      memwb_dmem_load_i = ld_hold_q;
      if (state_q == IDLE) begin
         dif.dmemREN = exm_dREN & exm_valid;
         dif.dmemWEN = exm_dWEN & exm_valid;
         mem_stall   = op & ~dif.dhit;
         if (dif.dhit)
            memwb_dmem_load_i = dif.dmemload;
      end
      if (RST) begin
         dif.dmemREN = 1'b0;
         dif.dmemWEN = 1'b0;
         mem_stall   = 1'b0;
      end
   end

   assign dif.dmemaddr  = exm_alu_out;
   assign dif.dmemstore = exm_store;

   assign memwb_regWr_i      = exm_regWr & exm_valid;
   assign memwb_halt_i       = exm_halt & exm_valid;
   assign memwb_mem_to_reg_i = exm_mem_to_reg;
   assign memwb_alu_out_i    = exm_alu_out;
   assign memwb_pc_p4_i      = exm_pc_p4;
   assign memwb_up_imm_i     = exm_up_imm;
   assign memwb_imem_load_i  = exm_instr;
   assign memwb_wsel_i       = exm_wsel;

   assign halted = (state_q == HALTED);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK (CLK),
      .inc (mem_stall),
      .clr (RST),
      .q   (stall_cnt)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
   import cpu_types_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       exm_valid, exm_dREN, exm_dWEN, exm_regWr, exm_halt;
   word_t      exm_alu_out, exm_store, exm_pc_p4, exm_up_imm, exm_instr;
   logic [1:0] exm_mem_to_reg;
   regbits_t   exm_wsel;
   logic       wb_en, wb_flush;
   logic       mem_stall, memwb_regWr_i, memwb_halt_i, halted;
   logic [1:0] memwb_mem_to_reg_i;
   word_t      memwb_dmem_load_i, memwb_alu_out_i, memwb_pc_p4_i, memwb_up_imm_i, memwb_imem_load_i;
   regbits_t   memwb_wsel_i;
   logic [15:0] stall_cnt;

   mem_access_unit_if dif();

   mem_access_unit #(.CNT_W(16)) dut (
      .CLK(CLK), .RST(RST),
      .exm_valid(exm_valid), .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN),
      .exm_alu_out(exm_alu_out), .exm_store(exm_store),
      .exm_regWr(exm_regWr), .exm_halt(exm_halt), .exm_mem_to_reg(exm_mem_to_reg),
      .exm_wsel(exm_wsel), .exm_pc_p4(exm_pc_p4), .exm_up_imm(exm_up_imm), .exm_instr(exm_instr),
      .dif(dif.master),
      .wb_en(wb_en), .wb_flush(wb_flush), .mem_stall(mem_stall),
      .memwb_regWr_i(memwb_regWr_i), .memwb_halt_i(memwb_halt_i),
      .memwb_mem_to_reg_i(memwb_mem_to_reg_i), .memwb_dmem_load_i(memwb_dmem_load_i),
      .memwb_alu_out_i(memwb_alu_out_i), .memwb_pc_p4_i(memwb_pc_p4_i),
      .memwb_up_imm_i(memwb_up_imm_i), .memwb_imem_load_i(memwb_imem_load_i),
      .memwb_wsel_i(memwb_wsel_i), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string nm;
      logic  ren, wen, stall, hlt;
      int    cnt;
      logic  chk_addr;  word_t addr;
      logic  chk_store; word_t store;
      logic  chk_load;  word_t load;
      logic  chk_wr;    logic  wr;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t mk(string nm, logic ren, logic wen, logic stall, logic hlt, int cnt);
      exp_t e;
      e.nm = nm; e.ren = ren; e.wen = wen; e.stall = stall; e.hlt = hlt; e.cnt = cnt;
      e.chk_addr = 0; e.addr = '0; e.chk_store = 0; e.store = '0;
      e.chk_load = 0; e.load = '0; e.chk_wr = 0; e.wr = 0;
      return e;
   endfunction

   task automatic cmp(string nm, string fld, word_t act, word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: pop one expectation per cycle and compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp(e.nm, "dmemREN",   word_t'(dif.dmemREN), word_t'(e.ren));
            cmp(e.nm, "dmemWEN",   word_t'(dif.dmemWEN), word_t'(e.wen));
            cmp(e.nm, "mem_stall", word_t'(mem_stall),   word_t'(e.stall));
            cmp(e.nm, "halted",    word_t'(halted),      word_t'(e.hlt));
            cmp(e.nm, "stall_cnt", word_t'(stall_cnt),   word_t'(e.cnt));
            if (e.chk_addr)  cmp(e.nm, "dmemaddr",  dif.dmemaddr,  e.addr);
            if (e.chk_store) cmp(e.nm, "dmemstore", dif.dmemstore, e.store);
            if (e.chk_load)  cmp(e.nm, "dmem_load_i", memwb_dmem_load_i, e.load);
            if (e.chk_wr)    cmp(e.nm, "regWr_i", word_t'(memwb_regWr_i), word_t'(e.wr));
         end
      end
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
      exm_valid = 0; exm_dREN = 0; exm_dWEN = 0; exm_halt = 0; exm_regWr = 0;
      exm_alu_out = '0; exm_store = '0;
      dif.dhit = 0; dif.dmemload = '0; wb_en = 1; wb_flush = 0;
   endtask

   task automatic set_op(logic ld, logic st, word_t addr, word_t data);
      exm_valid = 1; exm_dREN = ld; exm_dWEN = st; exm_alu_out = addr; exm_store = data;
   endtask

   // Stimulus: directed cycles, each pushing its hand-computed expectation
   initial begin
      exp_t e;
      exm_valid = 0; exm_dREN = 0; exm_dWEN = 0; exm_halt = 0; exm_regWr = 0;
      exm_alu_out = '0; exm_store = '0; exm_mem_to_reg = MTR_MEM; exm_wsel = 5'd7;
      exm_pc_p4 = 32'h4; exm_up_imm = '0; exm_instr = 32'h8C000000;
      dif.dhit = 0; dif.dmemload = '0; wb_en = 1; wb_flush = 0;
      repeat (2) @(posedge CLK);

      // Reset cycle with a request presented: forced off
      next_cycle(); RST = 1; set_op(1, 0, 32'h55, 0);
      sbq.push_back(mk("reset", 0, 0, 0, 0, 0));

      // Load hit, zero latency
      next_cycle(); RST = 0; set_op(1, 0, 32'h100, 0); exm_regWr = 1;
      dif.dhit = 1; dif.dmemload = 32'hDEADBEEF;
      e = mk("load_hit", 1, 0, 0, 0, 0); e.chk_addr = 1; e.addr = 32'h100;
      e.chk_load = 1; e.load = 32'hDEADBEEF; e.chk_wr = 1; e.wr = 1; sbq.push_back(e);

      next_cycle(); exm_regWr = 1;
      e = mk("bubble", 0, 0, 0, 0, 0); e.chk_wr = 1; e.wr = 0; sbq.push_back(e);

      // Store miss for 3 cycles then hit
      for (int i = 0; i < 4; i++) begin
         next_cycle(); set_op(0, 1, 32'h200, 32'h12345678); dif.dhit = (i == 3);
         e = mk($sformatf("store_miss%0d", i), 0, 1, (i != 3), 0, i);
         e.chk_addr = 1; e.addr = 32'h200; e.chk_store = 1; e.store = 32'h12345678;
         sbq.push_back(e);
      end
      next_cycle();
      sbq.push_back(mk("after_miss", 0, 0, 0, 0, 3));

      // Freeze after load hit: HOLD keeps data and drops request
      next_cycle(); set_op(1, 0, 32'h300, 0); dif.dhit = 1; dif.dmemload = 32'hCAFE0001; wb_en = 0;
      e = mk("freeze_hit", 1, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'hCAFE0001; sbq.push_back(e);
      next_cycle(); set_op(1, 0, 32'h300, 0); wb_en = 0;
      e = mk("hold0", 0, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'hCAFE0001; sbq.push_back(e);
      next_cycle(); set_op(1, 0, 32'h300, 0); wb_en = 1;
      e = mk("hold1", 0, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'hCAFE0001; sbq.push_back(e);
      next_cycle();
      e = mk("idle_after_hold", 0, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'hCAFE0001; sbq.push_back(e);

      // Duplicate store guard, then back-to-back ops with no bubble
      next_cycle(); set_op(0, 1, 32'h400, 32'hA5A5); dif.dhit = 1; wb_en = 0;
      sbq.push_back(mk("dup_st_hit", 0, 1, 0, 0, 3));
      next_cycle(); set_op(0, 1, 32'h400, 32'hA5A5); wb_en = 0;
      sbq.push_back(mk("dup_st_hold0", 0, 0, 0, 0, 3));
      next_cycle(); set_op(0, 1, 32'h400, 32'hA5A5); wb_en = 1;
      sbq.push_back(mk("dup_st_hold1", 0, 0, 0, 0, 3));
      next_cycle(); set_op(1, 0, 32'h404, 0); dif.dhit = 1; dif.dmemload = 32'h0BADF00D;
      e = mk("b2b_load", 1, 0, 0, 0, 3); e.chk_addr = 1; e.addr = 32'h404;
      e.chk_load = 1; e.load = 32'h0BADF00D; sbq.push_back(e);
      next_cycle(); set_op(0, 1, 32'h408, 32'h99); dif.dhit = 1;
      e = mk("b2b_store", 0, 1, 0, 0, 3); e.chk_addr = 1; e.addr = 32'h408; sbq.push_back(e);

      // Flush in HOLD discards the held load
      next_cycle(); set_op(1, 0, 32'h500, 0); dif.dhit = 1; dif.dmemload = 32'h11112222; wb_en = 0;
      sbq.push_back(mk("flush_hit", 1, 0, 0, 0, 3));
      next_cycle(); set_op(1, 0, 32'h500, 0); wb_en = 0; wb_flush = 1;
      e = mk("flush_hold", 0, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'h11112222; sbq.push_back(e);
      next_cycle();
      e = mk("after_flush", 0, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'h0; sbq.push_back(e);

      // dhit with no live instruction must not enter HOLD
      next_cycle(); dif.dhit = 1; dif.dmemload = 32'h77; wb_en = 0;
      e = mk("stray_dhit", 0, 0, 0, 0, 3); e.chk_load = 1; e.load = 32'h77; sbq.push_back(e);
      next_cycle(); set_op(1, 0, 32'h510, 0);
      sbq.push_back(mk("still_idle", 1, 0, 1, 0, 3));
      next_cycle(); set_op(1, 0, 32'h510, 0); dif.dhit = 1;
      sbq.push_back(mk("still_idle_hit", 1, 0, 0, 0, 4));

      // Halt: sticky, blocks requests, cleared only by reset
      next_cycle(); exm_valid = 1; exm_halt = 1;
      sbq.push_back(mk("halt_issue", 0, 0, 0, 0, 4));
      for (int i = 0; i < 2; i++) begin
         next_cycle(); set_op(1, 0, 32'h600, 0);
         sbq.push_back(mk($sformatf("halted%0d", i), 0, 0, 0, 1, 4));
      end
      next_cycle(); RST = 1; set_op(1, 0, 32'h600, 0);
      sbq.push_back(mk("halt_rst", 0, 0, 0, 1, 4));
      next_cycle(); RST = 0; set_op(1, 0, 32'h600, 0); dif.dhit = 1; dif.dmemload = 32'h600DF00D;
      e = mk("post_halt_rst", 1, 0, 0, 0, 0); e.chk_load = 1; e.load = 32'h600DF00D; sbq.push_back(e);

      // Reset during the second stall cycle of a miss
      next_cycle(); set_op(1, 0, 32'h700, 0);
      sbq.push_back(mk("rmiss0", 1, 0, 1, 0, 0));
      next_cycle(); RST = 1; set_op(1, 0, 32'h700, 0);
      sbq.push_back(mk("rmiss1_rst", 0, 0, 0, 0, 1));
      next_cycle(); RST = 0;
      sbq.push_back(mk("rmiss_after", 0, 0, 0, 0, 0));

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
